// File: rtl/sched_pkg.sv
// Shared definitions for the scheduler enqueue/dispatch slice: FSM state type,
// tuser field offsets and a 16-bit saturating adder used for packet byte counts.
package sched_pkg;

    // Packet-level states of the enqueue dispatcher
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } sched_state_t;

    // SUME metadata layout inside tuser (lower 128 bits), PIFO info above it
    localparam int PKT_LEN_LSB      = 0;
    localparam int PKT_LEN_WIDTH    = 16;
    localparam int SRC_PORT_LSB     = 16;
    localparam int DST_PORT_LSB     = 24;
    localparam int SUME_META_WIDTH  = 128;
    localparam int PIFO_INFO_LSB    = SUME_META_WIDTH;
    localparam int PIFO_INFO_LENGTH = 68;

    // Width of the per-packet byte accumulator
    localparam int PKT_BYTES_WIDTH  = 16;

    // Add two byte counts, clamping at 0xFFFF instead of wrapping
    function automatic logic [PKT_BYTES_WIDTH-1:0] sat_add16(
        input logic [PKT_BYTES_WIDTH-1:0] a,
        input logic [PKT_BYTES_WIDTH-1:0] b
    );
        logic [PKT_BYTES_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PKT_BYTES_WIDTH] ? {PKT_BYTES_WIDTH{1'b1}} : sum[PKT_BYTES_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/keep_popcount.sv
// Combinational population count of a tkeep vector: number of valid bytes in a beat.
module keep_popcount #(
    parameter int KEEP_WIDTH  = 32,
    parameter int COUNT_WIDTH = $clog2(KEEP_WIDTH + 1)
) (
    input  logic [KEEP_WIDTH-1:0]  keep,
    output logic [COUNT_WIDTH-1:0] count
);

    // Sum the enable bits one by one; synthesis folds this into an adder tree
    always_comb begin
        count = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            count = count + COUNT_WIDTH'(keep[i]);
        end
    end

endmodule

// File: rtl/sched_enqueue_dispatch.sv
// Enqueue dispatcher: steers each ingress packet to its one-hot destination
// queues, writing every beat to the queues that had room at the first beat and
// dropping the packet for the queues that were almost full.
// Optional drop statistics (pkt_dropped / bytes_dropped) are built only when the
// macro SCHED_DROP_STATS_EN is defined; otherwise those outputs are tied to 0.
module sched_enqueue_dispatch #(
    parameter int NUM_QUEUES           = 5,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 196,
    parameter int DST_PORT_LSB         = sched_pkg::DST_PORT_LSB,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                              axis_aclk,
    input  logic                              axis_resetn,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    output logic                              s_axis_tready,
    input  logic [NUM_QUEUES-1:0]             s_axis_buffer_almost_full,
    output logic [NUM_QUEUES-1:0]             m_axis_ctl_buffer_wr_en,
    output logic [NUM_QUEUES-1:0]             m_axis_ctl_pifo_in_en,
    output logic [NUM_QUEUES-1:0]             pkt_stored,
    output logic [NUM_QUEUES-1:0]             pkt_dropped,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     bytes_dropped
);

    import sched_pkg::*;

    localparam int KEEP_WIDTH  = C_S_AXIS_DATA_WIDTH / 8;
    localparam int COUNT_WIDTH = $clog2(KEEP_WIDTH + 1);

    sched_state_t                 state;
    logic [NUM_QUEUES-1:0]        accept_q;
    logic [PKT_BYTES_WIDTH-1:0]   acc_bytes;

    logic                         transfer;
    logic                         first_beat;
    logic [NUM_QUEUES-1:0]        dst;
    logic [NUM_QUEUES-1:0]        cur_accept;
    logic [COUNT_WIDTH-1:0]       beat_bytes;
    logic [PKT_BYTES_WIDTH-1:0]   pkt_bytes;
    logic                         unused_tuser;

    // Only the destination field of tuser is consumed here
    assign unused_tuser = ^s_axis_tuser;

    assign transfer   = s_axis_tvalid && s_axis_tready;
    assign first_beat = (state == IDLE);
    assign dst        = s_axis_tuser[DST_PORT_LSB +: NUM_QUEUES];

    // On the first beat the masks come straight from dst/almost_full; afterwards
    // the latched value is used so later almost_full changes are ignored
    assign cur_accept = first_beat ? (dst & ~s_axis_buffer_almost_full) : accept_q;

    keep_popcount #(
        .KEEP_WIDTH  (KEEP_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_keep_popcount (
        .keep  (s_axis_tkeep),
        .count (beat_bytes)
    );

    // Running packet size including the current beat; restarts on a first beat
    assign pkt_bytes = sat_add16(first_beat ? '0 : acc_bytes, PKT_BYTES_WIDTH'(beat_bytes));

    // Zero-latency queue write and PIFO insert strobes for the beat on the bus
    always_comb begin
        m_axis_ctl_buffer_wr_en = '0;
        m_axis_ctl_pifo_in_en   = '0;
        if (transfer) begin
            m_axis_ctl_buffer_wr_en = cur_accept;
            if (s_axis_tlast) begin
                m_axis_ctl_pifo_in_en = cur_accept;
            end
        end
    end

    // Packet FSM with latched accept mask, byte accumulator, ready and store pulse
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state         <= IDLE;
            accept_q      <= '0;
            acc_bytes     <= '0;
            s_axis_tready <= 1'b0;
            pkt_stored    <= '0;
        end else begin
            s_axis_tready <= 1'b1;
            pkt_stored    <= (transfer && s_axis_tlast) ? cur_accept : '0;
            if (transfer) begin
                acc_bytes <= s_axis_tlast ? '0 : pkt_bytes;
                case (state)
                    IDLE: begin
                        accept_q <= cur_accept;
                        if (!s_axis_tlast) begin
                            state <= (cur_accept != '0) ? WRITE : DROP;
                        end
                    end
                    WRITE, DROP: begin
                        if (s_axis_tlast) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SCHED_DROP_STATS_EN
    logic [NUM_QUEUES-1:0]       drop_q;
    logic [NUM_QUEUES-1:0]       cur_drop;
    logic [C_S_AXI_DATA_WIDTH:0] drop_sum;

    assign cur_drop = first_beat ? (dst & s_axis_buffer_almost_full) : drop_q;
    assign drop_sum = {1'b0, bytes_dropped} + (C_S_AXI_DATA_WIDTH + 1)'(pkt_bytes);

    // Drop mask latch, per-queue drop pulse and saturating dropped-byte total
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            drop_q        <= '0;
            pkt_dropped   <= '0;
            bytes_dropped <= '0;
        end else begin
            pkt_dropped <= (transfer && s_axis_tlast) ? cur_drop : '0;
            if (transfer && first_beat) begin
                drop_q <= cur_drop;
            end
            if (transfer && s_axis_tlast && (cur_drop != '0)) begin
                bytes_dropped <= drop_sum[C_S_AXI_DATA_WIDTH] ? '1
                                                              : drop_sum[C_S_AXI_DATA_WIDTH-1:0];
            end
        end
    end
`else
    assign pkt_dropped   = '0;
    assign bytes_dropped = '0;
`endif

endmodule

// File: doc/sched_enqueue_dispatch.md
SCHED_ENQUEUE_DISPATCH -- requirements
Module: sched_enqueue_dispatch

Interface
REQ-001 Parameter NUM_QUEUES, default 5: number of output queues; the top index is the CPU/DMA queue.
REQ-002 Parameter C_S_AXIS_DATA_WIDTH, default 256: stream data width; tkeep is C_S_AXIS_DATA_WIDTH/8 bits.
REQ-003 Parameter C_S_AXIS_TUSER_WIDTH, default 196: sume metadata plus PIFO info.
REQ-004 Parameter DST_PORT_LSB, default 24: the one-hot destination bit for queue i is tuser[DST_PORT_LSB+i].
REQ-005 Parameter C_S_AXI_DATA_WIDTH, default 32: width of the byte counter.
REQ-006 axis_aclk  in  1  the single clock; all logic is rising-edge.
REQ-007 axis_resetn  in  1  asynchronous, active-low reset.
REQ-008 s_axis_tvalid / s_axis_tlast  in  1 each  ingress beat qualifiers.
REQ-009 s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables.
REQ-010 s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  metadata; only the first beat is sampled.
REQ-011 s_axis_tready  out  1  ingress ready.
REQ-012 s_axis_buffer_almost_full  in  NUM_QUEUES  per-queue almost-full flags.
REQ-013 m_axis_ctl_buffer_wr_en  out  NUM_QUEUES  per-queue beat write enable.
REQ-014 m_axis_ctl_pifo_in_en  out  NUM_QUEUES  per-queue PIFO insert pulse.
REQ-015 pkt_stored  out  NUM_QUEUES  registered per-queue accept pulse.
REQ-016 pkt_dropped  out  NUM_QUEUES  registered per-queue drop pulse.
REQ-017 bytes_dropped  out  C_S_AXI_DATA_WIDTH  cumulative dropped-byte count.

Function
REQ-018 A beat is transferred when s_axis_tvalid and s_axis_tready are both high.
REQ-019 The state machine SHALL have three states: IDLE (expects the first beat), WRITE (forwarding an accepted packet), DROP (sinking a fully dropped packet).
REQ-020 On the IDLE first beat, accept = dst & ~almost_full and dropmask = dst & almost_full; both are latched for the whole packet.
REQ-021 IDLE first beat with accept≠0 and no tlast: go to WRITE. With accept=0 and no tlast: go to DROP. With tlast: stay in IDLE.
REQ-022 WRITE and DROP SHALL return to IDLE on the tlast transfer.
REQ-023 m_axis_ctl_buffer_wr_en SHALL equal the accept mask, combinationally, on every transferred beat of an accepted packet (zero latency), including the first beat; it is 0 otherwise.
REQ-024 m_axis_ctl_pifo_in_en SHALL equal the accept mask only on the tlast transfer; it is a 1-cycle pulse and 0 otherwise.
REQ-025 A change on almost_full mid-packet SHALL be ignored; the queue threshold guarantees room for one maximum-size packet.
REQ-026 A partial accept (some destination queues full) SHALL write to the accepted queues and count a drop for the full queues.
REQ-027 A destination mask of zero SHALL be handled as a drop with dropmask=0: no pulse and no byte count.
REQ-028 s_axis_tready SHALL be 0 in reset, go to 1 one cycle after reset deassertion, and never be deasserted by a drop.
REQ-029 Packet bytes SHALL be the sum of popcount(tkeep) over all transferred beats, held in a 16-bit accumulator that saturates at 0xFFFF.
REQ-030 pkt_stored SHALL pulse with the accept mask one cycle after the tlast transfer.
REQ-031 A single-beat packet (first beat also tlast) SHALL produce wr_en and pifo_in_en in the same cycle.
REQ-032 Back-to-back packets with no idle cycle between them SHALL be supported: the beat after tlast is a first beat.

Reset
REQ-033 Reset values: state IDLE, latched masks 0, accumulator 0, s_axis_tready 0, pkt_stored 0, pkt_dropped 0, bytes_dropped 0; wr_en and pifo_in_en are 0 while reset is asserted.
REQ-034 Reset asserted mid-packet SHALL abandon the packet; the first beat transferred after reset is treated as a new first beat.

Configuration
REQ-035 With SCHED_DROP_STATS_EN defined: pkt_dropped pulses dropmask one cycle after the tlast transfer of a packet with dropmask≠0, and bytes_dropped adds that packet's bytes, saturating at all-ones.
REQ-036 Without SCHED_DROP_STATS_EN: pkt_dropped and bytes_dropped are tied to 0 and no drop-counter logic is synthesised; all other behaviour is unchanged.

Structure
REQ-037 Shared package sched_pkg SHALL hold the state type (IDLE/WRITE/DROP), DST_PORT_LSB, PIFO_INFO_LENGTH=68 and the tuser field offsets.
REQ-038 Sub-module keep_popcount (tkeep in, byte count out, combinational) SHALL be instantiated once.

Verification
REQ-039 dst=0b00001, almost_full=0, 3-beat packet with full tkeep: wr_en=0b00001 on 3 beats, pifo_in_en=0b00001 on beat 3 only, pkt_stored pulses next cycle.
REQ-040 dst=0b00110, almost_full=0b00100, 2 beats (32+10 bytes): wr_en=0b00010; pkt_dropped=0b00100; bytes_dropped=42.
REQ-041 dst=0b00001, almost_full=0b00001, 4 beats: DROP state, tready stays 1, wr_en=0; bytes_dropped=128 with the macro defined, 0 without it.
REQ-042 almost_full rises on beat 2 of an accepted 3-beat packet: all 3 beats are still written; the next packet to that queue is dropped.
REQ-043 Single-beat packet immediately followed by a 2-beat packet: both are accepted with no bubble; reset pulsed mid-packet: state returns to IDLE and the next beat is treated as a first beat.
